serial_counts_receiver: RTL and testbench

Receive-side counterpart of the CCU serial count link: a UART receiver that deserializes the 8N1 byte stream produced by the counter board and rebuilds the nine per-channel coincidence count bytes in a register bank. It sits on the host/readout FPGA or a loopback test board. It has its own baud timing, a line synchronizer, a receive FSM, a slot sequencer that resynchronizes on idle gaps, and frame-error handling.

---
 rtl/serial_counts_receiver.sv | 168 ++++++++++++++++
 tb/tb_serial_counts_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_counts_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_counts_receiver: 8N1 UART receiver rebuilding a 9-slot count bank |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_counts_receiver #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 4_000_000,
  parameter int CLKS_PER_BIT  = CLK_FREQ / BAUD_RATE,
  parameter int IDLE_GAP_BITS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [3:0] slot,
  output logic       frame_error,
  output logic       bank_valid,
  output logic [7:0] counts_A,
  output logic [7:0] counts_B,
  output logic [7:0] counts_BP,
  output logic [7:0] counts_AP,
  output logic [7:0] counts_AB,
  output logic [7:0] counts_ABP,
  output logic [7:0] counts_APB,
  output logic [7:0] counts_APBP,
  output logic [7:0] counts_ABBP
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int GAP  = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int GW   = $clog2(GAP + 1);

  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_END      = GW'(GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            rx_meta;
  logic            rxs;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            stop_wait;
  logic [GW-1:0]   gap_cnt;
  logic            shift_en;
  logic            stop_ok;
  logic            stop_bad;
  logic [7:0]      bank [9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) state_nx = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF_END) state_nx = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (clk_cnt == CNT_BIT_END) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        // After a framing error the line must return high before a new start is hunted.
        if (stop_wait) begin
          if (rxs) state_nx = IDLE;
        end else if (clk_cnt == CNT_BIT_END) begin
          if (rxs) begin
            stop_ok  = 1'b1;
            state_nx = IDLE;
          end else begin
            stop_bad = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      stop_wait <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state || shift_en || state == IDLE) clk_cnt <= '0;
      else                                              clk_cnt <= clk_cnt + CW'(1);
      if (state_nx != state) bit_cnt <= 3'd0;
      else if (shift_en)     bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {rxs, shreg[7:1]};
      if (state_nx != state) stop_wait <= 1'b0;
      else if (stop_bad)     stop_wait <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state != IDLE || !rxs) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_END) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      bank_valid  <= 1'b0;
      slot        <= 4'd0;
      for (int i = 0; i < 9; i++) bank[i] <= 8'h00;
    end else begin
      data_valid  <= stop_ok;
      frame_error <= stop_bad;
      bank_valid  <= stop_ok && (slot == 4'd8);
      if (stop_ok) begin
        data       <= shreg;
        bank[slot] <= shreg;
        slot       <= (slot == 4'd8) ? 4'd0 : slot + 4'd1;
      end else if (gap_cnt == GAP_END) begin
        slot <= 4'd0;
      end
    end
  end

  assign counts_A    = bank[0];
  assign counts_B    = bank[1];
  assign counts_BP   = bank[2];
  assign counts_AP   = bank[3];
  assign counts_AB   = bank[4];
  assign counts_ABP  = bank[5];
  assign counts_APB  = bank[6];
  assign counts_APBP = bank[7];
  assign counts_ABBP = bank[8];

endmodule
`default_nettype wire

// File: tb/tb_serial_counts_receiver.sv
`default_nettype none
// Directed bench for serial_counts_receiver with an expected-event scoreboard.
module tb_serial_counts_receiver;

  localparam int C = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic [3:0] slot;
  logic       frame_error;
  logic       bank_valid;
  logic [7:0] counts_A, counts_B, counts_BP, counts_AP, counts_AB;
  logic [7:0] counts_ABP, counts_APB, counts_APBP, counts_ABBP;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       fe;
    logic [7:0] d;
    logic [3:0] wslot;
    logic [3:0] slot_after;
    logic       bv;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_slot = 4'd0;

  serial_counts_receiver dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data(data), .data_valid(data_valid), .slot(slot),
    .frame_error(frame_error), .bank_valid(bank_valid),
    .counts_A(counts_A), .counts_B(counts_B), .counts_BP(counts_BP),
    .counts_AP(counts_AP), .counts_AB(counts_AB), .counts_ABP(counts_ABP),
    .counts_APB(counts_APB), .counts_APBP(counts_APBP), .counts_ABBP(counts_ABBP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_count(input logic [3:0] idx);
    case (idx)
      4'd0: return counts_A;
      4'd1: return counts_B;
      4'd2: return counts_BP;
      4'd3: return counts_AP;
      4'd4: return counts_AB;
      4'd5: return counts_ABP;
      4'd6: return counts_APB;
      4'd7: return counts_APBP;
      default: return counts_ABBP;
    endcase
  endfunction

  // Each call starts on a falling edge and ends on one; the line is driven one bit per C clocks.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    exp_t e;
    e.fe    = !good;
    e.d     = b;
    e.wslot = m_slot;
    e.bv    = good && (m_slot == 4'd8);
    if (good) m_slot = (m_slot == 4'd8) ? 4'd0 : m_slot + 4'd1;
    e.slot_after = m_slot;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * C) @(negedge clk);
    if (n >= 12) m_slot = 4'd0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_error || bank_valid)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, data_valid, frame_error, bank_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_error", frame_error, e.fe);
        chk("data_valid", data_valid, !e.fe);
        chk("bank_valid", bank_valid, e.bv);
        chk("slot_after", slot, e.slot_after);
        if (!e.fe) begin
          chk("data", data, e.d);
          chk("bank_slot", get_count(e.wslot), e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    repeat (5) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_slot", slot, 0);
    chk("rst_pulses", {data_valid, frame_error, bank_valid}, 0);
    chk("rst_counts_A", counts_A, 0);
    chk("rst_counts_ABBP", counts_ABBP, 0);
    rst_n = 1'b1;

    // Full bank after a 20-bit gap, bytes back to back.
    idle_bits(20);
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i * 17);
      send_byte(b, 1'b1);
    end
    idle_bits(2);
    chk("bank_A", counts_A, 8'h11);
    chk("bank_B", counts_B, 8'h22);
    chk("bank_BP", counts_BP, 8'h33);
    chk("bank_AP", counts_AP, 8'h44);
    chk("bank_AB", counts_AB, 8'h55);
    chk("bank_ABP", counts_ABP, 8'h66);
    chk("bank_APB", counts_APB, 8'h77);
    chk("bank_APBP", counts_APBP, 8'h88);
    chk("bank_ABBP", counts_ABBP, 8'h99);
    chk("bank_slot_wrap", slot, 0);
    chk("bank_q_empty", q.size(), 0);

    // Latency: stop sampled at T0+239, data_valid high in the following cycle.
    idle_bits(20);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (238) @(posedge clk);
        #1 chk("dv_before_t240", data_valid, 0);
        @(posedge clk);
        #1 chk("dv_at_t240", data_valid, 1);
        chk("data_at_t240", data, 8'hA5);
        chk("slot_at_t240", slot, 1);
      end
    join

    // Framing error, then a good byte into the same slot.
    send_byte(8'h3C, 1'b0);
    idle_bits(2);
    chk("fe_data_hold", data, 8'hA5);
    chk("fe_slot_hold", slot, 1);
    chk("fe_bank_hold", counts_B, 8'h22);
    send_byte(8'h5A, 1'b1);
    idle_bits(2);
    chk("after_fe_counts_B", counts_B, 8'h5A);
    chk("after_fe_slot", slot, 2);

    // Short low glitch is rejected.
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    chk("glitch_slot", slot, 2);
    chk("glitch_q_empty", q.size(), 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle_bits(12);
    chk("gap_slot_zero", slot, 0);
    chk("gap_counts_AB", counts_AB, 8'h03);
    send_byte(8'h77, 1'b1);
    idle_bits(2);
    chk("gap_counts_A", counts_A, 8'h77);
    chk("gap_slot_one", slot, 1);

    // Reset during data bit 4 of a frame.
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    m_slot = 4'd0;
    repeat (3) @(negedge clk);
    chk("midrst_data", data, 0);
    chk("midrst_slot", slot, 0);
    chk("midrst_pulses", {data_valid, frame_error, bank_valid}, 0);
    chk("midrst_counts_A", counts_A, 0);
    chk("midrst_counts_AB", counts_AB, 0);
    rst_n = 1'b1;
    idle_bits(2);
    send_byte(8'hE7, 1'b1);
    idle_bits(2);
    chk("post_rst_counts_A", counts_A, 8'hE7);
    chk("post_rst_counts_B", counts_B, 0);
    chk("post_rst_slot", slot, 1);
    chk("final_q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
